// File: rtl/chaos_pkg.sv
// Shared types and helpers for the logistic-map generator and its LFSR mixer.
package chaos_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL1 = 2'd1,
        MUL2 = 2'd2,
        HOLD = 2'd3
    } state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Full-width product then truncating shift; operands are zero-extended by the caller.
    function automatic logic [63:0] q_mul(input logic [63:0] a, input logic [63:0] b,
                                          input int unsigned frac);
        logic [63:0] prod;
        prod = a * b;
        return prod >> frac;
    endfunction

endpackage

// File: rtl/chaos_lfsr16.sv
// 16-bit Galois LFSR used to whiten the map output when LFSR_MIX_EN is defined.
module chaos_lfsr16
    import chaos_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        step,
    output logic [15:0] lfsr_out
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load) begin
            lfsr_d = LFSR_SEED;
        end else if (step) begin
            lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_out = lfsr_q;

endmodule

// File: rtl/chaotic_map_gen.sv
// Fixed-point logistic-map generator x' = r*x*(1-x) with burn-in, backpressure and stuck recovery.
// Optional output whitening with a 16-bit LFSR when LFSR_MIX_EN is defined.
module chaotic_map_gen
    import chaos_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8,
    parameter int BURN  = 0,
    parameter int KICK  = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] x_init,
    input  logic [WIDTH-1:0] r,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             stuck,
    output logic [CNT_W-1:0] iter_cnt
);

    localparam int               BURN_W = (BURN > 0) ? $clog2(BURN + 1) : 1;
    localparam logic [WIDTH-1:0] ONE    = WIDTH'(1) << FRAC;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   x_q, x_d;
    logic [WIDTH-1:0]   r_q, r_d;
    logic [WIDTH-1:0]   p1_q, p1_d;
    logic [BURN_W-1:0]  burn_q, burn_d;
    logic [CNT_W-1:0]   iter_q, iter_d;
    logic               valid_q, valid_d;
    logic               stuck_q, stuck_d;
    logic [WIDTH-1:0]   t;
    logic [WIDTH-1:0]   xn;
    logic               accept;

    // Clamp a widened result to the all-ones code when anything spills above WIDTH bits.
    function automatic logic [WIDTH-1:0] sat_w(input logic [63:0] v);
        if ((v >> WIDTH) != 64'd0) begin
            return '1;
        end
        return v[WIDTH-1:0];
    endfunction

    assign accept = valid_q & out_ready;

    always_comb begin
        t = (x_q <= ONE) ? (ONE - x_q) : '0;
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        r_d     = r_q;
        p1_d    = p1_q;
        burn_d  = burn_q;
        iter_d  = iter_q;
        valid_d = valid_q;
        stuck_d = stuck_q;
        xn      = '0;

        case (state_q)
            IDLE: ;
            MUL1: begin
                p1_d    = sat_w(q_mul(64'(x_q), 64'(t), FRAC));
                state_d = MUL2;
            end
            MUL2: begin
                xn = sat_w(q_mul(64'(r_q), 64'(p1_q), FRAC));
                if (xn == '0) begin
                    xn      = WIDTH'(KICK);
                    stuck_d = 1'b1;
                end
                x_d = xn;
                if (burn_q != '0) begin
                    burn_d  = burn_q - 1'b1;
                    state_d = MUL1;
                end else begin
                    valid_d = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (accept) begin
                    valid_d = 1'b0;
                    iter_d  = iter_q + 1'b1;
                    state_d = MUL1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A start from any state aborts the iteration in flight and reloads.
        if (start) begin
            x_d     = x_init;
            r_d     = r;
            burn_d  = BURN_W'(BURN);
            iter_d  = '0;
            stuck_d = 1'b0;
            valid_d = 1'b0;
            state_d = MUL1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            x_q     <= '0;
            r_q     <= '0;
            p1_q    <= '0;
            burn_q  <= '0;
            iter_q  <= '0;
            valid_q <= 1'b0;
            stuck_q <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            r_q     <= r_d;
            p1_q    <= p1_d;
            burn_q  <= burn_d;
            iter_q  <= iter_d;
            valid_q <= valid_d;
            stuck_q <= stuck_d;
        end
    end

    assign out_valid = valid_q;
    assign busy      = (state_q != IDLE);
    assign stuck     = stuck_q;
    assign iter_cnt  = iter_q;

`ifdef LFSR_MIX_EN
    logic [15:0] lfsr;

    chaos_lfsr16 u_lfsr (
        .clk      (clk),
        .reset    (reset),
        .load     (start),
        .step     (accept),
        .lfsr_out (lfsr)
    );

    // Idle output stays at zero so the post-reset value is not the raw seed.
    assign out_data = (state_q == IDLE) ? x_q : (x_q ^ WIDTH'(lfsr));
`else
    assign out_data = x_q;
`endif

endmodule
